alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
Decode-to-execute buffer that sits directly upstream of the ALU. It accepts decoded instruction bundles from the IDU over a valid/ready handshake and selects the operands. It masks shift amounts, snoops writeback to keep held source operands current, and presents opnum1/opnum2/ALUctrl to the ALU from a 2-entry FIFO. Full-throughput, fully registered ready toward the IDU.

Parameters:
DEPTH, 2, FIFO entries (fixed at 2; pointers are 1 bit)
XLEN, 32, datapath width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous; discard all held entries
in_valid  in  1  IDU bundle valid
in_ready  out  1  stage can accept (registered, = !full)
in_pc  in  32  instruction PC
in_rs1_addr  in  4  source 1 index (RV32E)
in_rs2_addr  in  4  source 2 index
in_rs1_data  in  32  regfile read 1
in_rs2_data  in  32  regfile read 2
in_imm  in  32  sign-extended immediate
in_src1_sel  in  2  0=rs1, 1=pc, 2=zero, 3=reserved (treated as zero)
in_src2_sel  in  1  0=rs2, 1=imm
in_alu_ctrl  in  4  ALU op: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 XOR, 6 SUB
in_rd  in  4  destination index (passed through)
wb_en  in  1  writeback write enable
wb_rd  in  4  writeback destination
wb_data  in  32  writeback value
out_valid  out  1  head entry valid
out_ready  in  1  EXU consumes head
opnum1  out  32  to ALU opnum1
opnum2  out  32  to ALU opnum2
alu_ctrl  out  4  to ALU ALUctrl
out_rd  out  4  destination of head
out_illegal  out  1  head op code >6

Behaviour:
- Reset (async, rst=1): both entries invalid, pointers=0, count=0. Outputs: out_valid=0, in_ready=1, opnum1=opnum2=0, alu_ctrl=0, out_rd=0, out_illegal=0.
- Entry stores: rs1/rs2 addresses, rs1/rs2 data, pc, imm, src selects, alu_ctrl, rd.
- Push when in_valid&&in_ready. Pop when out_valid&&out_ready. Push and pop in the same cycle when full is not allowed, because in_ready=0 then. Push and pop together when count=1: count stays 1 and the entry order is preserved.
- Latency: a bundle pushed in cycle N is visible at outputs in cycle N+1 (out_valid=1). There is no combinational path from in_* to out_*.
- Capture-time bypass: if wb_en && wb_rd!=0 && wb_rd==in_rsX_addr during the push cycle, the entry stores wb_data instead of in_rsX_data.
- Held-entry snoop: every cycle, for each valid entry and each source X, if wb_en && wb_rd!=0 && wb_rd==rsX_addr, the stored rsX data is replaced by wb_data. This applies to the head entry even when it is popped in that cycle; that update is harmless.
- Register x0 is never bypassed or snooped. An rs address of 0 always uses the captured data.
- Operand formation from the head entry, combinational off registers:
  - opnum1 = rs1 / pc / 0 / 0 per src1_sel.
  - opnum2 = rs2 or imm per src2_sel.
  - For alu_ctrl 3 or 4, opnum2 is masked to {27'b0, opnum2[4:0]}.
- out_illegal = head alu_ctrl > 6. alu_ctrl is still passed unmodified; the EXU decides the action.
- When out_valid=0, the outputs hold their last values, but consumers must ignore them.
- Flush: at the next edge, count=0 and out_valid=0. in_ready is 1 in the following cycle. A push that coincides with flush is dropped. Flush has priority over push and pop.
- Reset mid-operation: immediate clear, identical to the power-on reset values.
- Pointer wrap: 1-bit rd/wr pointers wrap modulo 2. Full = count==2, empty = count==0.

Test Plan:
1. Reset then push {src1=rs1, rs1_data=5, src2=imm, imm=7, ctrl=2}, out_ready=1 -> next cycle out_valid=1, opnum1=5, opnum2=7, alu_ctrl=2; the following cycle out_valid=0.
2. out_ready=0, push 3 bundles back-to-back -> first 2 accepted; in_ready=0 after the 2nd push; 3rd held by the IDU. Raise out_ready -> entries emerge in order, and in_ready returns to 1 one cycle after the first pop.
3. Hold an entry with rs2_addr=3 (data 0x10), then pulse wb_en, wb_rd=3, wb_data=0xABCD -> opnum2 becomes 0xABCD the next cycle. Repeat with wb_rd=0 -> no change.
4. Push ctrl=3 with rs2_data=0xFFFF_FFE5 -> opnum2=0x0000_0005. Push ctrl=6 with the same data -> opnum2=0xFFFF_FFE5.
5. Push src1_sel=1, pc=0x8000_0004 -> opnum1=0x8000_0004. Push ctrl=9 -> out_illegal=1.
6. Full FIFO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed push never appears. Assert rst asynchronously mid-stream -> outputs reach their reset values before the next edge.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: IDU-side bundle, writeback snoop and ALU-side operand bus for the operand stage
interface alu_operand_stage_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [3:0]      in_rs1_addr;
  logic [3:0]      in_rs2_addr;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic [1:0]      in_src1_sel;
  logic            in_src2_sel;
  logic [3:0]      in_alu_ctrl;
  logic [3:0]      in_rd;
  logic            wb_en;
  logic [3:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] opnum1;
  logic [XLEN-1:0] opnum2;
  logic [3:0]      alu_ctrl;
  logic [3:0]      out_rd;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_src1_sel, in_src2_sel, in_alu_ctrl, in_rd, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, opnum1, opnum2, alu_ctrl, out_rd, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_src1_sel, in_src2_sel, in_alu_ctrl, in_rd, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, opnum1, opnum2, alu_ctrl, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: 2-entry decode-to-execute FIFO with writeback snoop and ALU operand formation
module alu_operand_stage #(
  parameter int XLEN = 32
) (
  input logic                clk,
  input logic                rst,
  alu_operand_stage_if.slave bus
);
  logic [3:0]      r_rs1_addr [2];
  logic [3:0]      r_rs2_addr [2];
  logic [XLEN-1:0] r_rs1_data [2];
  logic [XLEN-1:0] r_rs2_data [2];
  logic [XLEN-1:0] r_pc       [2];
  logic [XLEN-1:0] r_imm      [2];
  logic [1:0]      r_src1_sel [2];
  logic            r_src2_sel [2];
  logic [3:0]      r_ctrl     [2];
  logic [3:0]      r_rd       [2];
  logic            r_rd_ptr;
  logic            r_wr_ptr;
  logic [1:0]      r_count;
  logic            r_in_ready;
  logic [XLEN-1:0] r_last_op1;
  logic [XLEN-1:0] r_last_op2;
  logic [3:0]      r_last_ctrl;
  logic [3:0]      r_last_rd;
  logic            r_last_ill;

  logic            w_push;
  logic            w_pop;
  logic            w_out_valid;
  logic            w_wb_ok;
  logic [1:0]      w_valid;
  logic [1:0]      w_next_count;
  logic [XLEN-1:0] w_cap_rs1;
  logic [XLEN-1:0] w_cap_rs2;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2_raw;
  logic [XLEN-1:0] w_op2;
  logic [3:0]      w_ctrl;

  assign w_out_valid  = r_count != 2'd0;
  assign w_push       = bus.in_valid && r_in_ready;
  assign w_pop        = w_out_valid && bus.out_ready;
  assign w_next_count = bus.flush ? 2'd0 : r_count + {1'b0, w_push} - {1'b0, w_pop};
  // x0 is hard-wired zero, so a writeback to it never overrides captured data
  assign w_wb_ok      = bus.wb_en && bus.wb_rd != 4'd0;
  assign w_valid      = r_count == 2'd2 ? 2'b11 : r_count == 2'd1 ? 2'b01 << r_rd_ptr : 2'b00;
  assign w_cap_rs1    = w_wb_ok && bus.wb_rd == bus.in_rs1_addr ? bus.wb_data : bus.in_rs1_data;
  assign w_cap_rs2    = w_wb_ok && bus.wb_rd == bus.in_rs2_addr ? bus.wb_data : bus.in_rs2_data;

  // Entry storage: capture on push (with writeback bypass), otherwise keep valid entries' sources current
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_rs1_addr[i] <= '0;
        r_rs2_addr[i] <= '0;
        r_rs1_data[i] <= '0;
        r_rs2_data[i] <= '0;
        r_pc[i]       <= '0;
        r_imm[i]      <= '0;
        r_src1_sel[i] <= '0;
        r_src2_sel[i] <= '0;
        r_ctrl[i]     <= '0;
        r_rd[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push && !bus.flush && r_wr_ptr == 1'(i)) begin
          r_rs1_addr[i] <= bus.in_rs1_addr;
          r_rs2_addr[i] <= bus.in_rs2_addr;
          r_rs1_data[i] <= w_cap_rs1;
          r_rs2_data[i] <= w_cap_rs2;
          r_pc[i]       <= bus.in_pc;
          r_imm[i]      <= bus.in_imm;
          r_src1_sel[i] <= bus.in_src1_sel;
          r_src2_sel[i] <= bus.in_src2_sel;
          r_ctrl[i]     <= bus.in_alu_ctrl;
          r_rd[i]       <= bus.in_rd;
        end else if (w_valid[i]) begin
          if (w_wb_ok && bus.wb_rd == r_rs1_addr[i]) r_rs1_data[i] <= bus.wb_data;
          if (w_wb_ok && bus.wb_rd == r_rs2_addr[i]) r_rs2_data[i] <= bus.wb_data;
        end
      end
    end
  end

  // Pointers, occupancy and registered ready; flush wins over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_rd_ptr   <= bus.flush ? 1'b0 : r_rd_ptr ^ w_pop;
      r_wr_ptr   <= bus.flush ? 1'b0 : r_wr_ptr ^ w_push;
      r_count    <= w_next_count;
      r_in_ready <= w_next_count != 2'd2;
    end
  end

  // Operand formation from the head entry; shifts only see the low 5 bits of the amount
  always_comb begin
    w_ctrl    = r_ctrl[r_rd_ptr];
    w_op1     = r_src1_sel[r_rd_ptr] == 2'd0 ? r_rs1_data[r_rd_ptr] :
                r_src1_sel[r_rd_ptr] == 2'd1 ? r_pc[r_rd_ptr] : '0;
    w_op2_raw = r_src2_sel[r_rd_ptr] ? r_imm[r_rd_ptr] : r_rs2_data[r_rd_ptr];
    w_op2     = w_ctrl == 4'd3 || w_ctrl == 4'd4 ? {{(XLEN-5){1'b0}}, w_op2_raw[4:0]} : w_op2_raw;
  end

  // Remember the last presented operands so the outputs hold steady while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_op1  <= '0;
      r_last_op2  <= '0;
      r_last_ctrl <= '0;
      r_last_rd   <= '0;
      r_last_ill  <= 1'b0;
    end else if (w_out_valid) begin
      r_last_op1  <= w_op1;
      r_last_op2  <= w_op2;
      r_last_ctrl <= w_ctrl;
      r_last_rd   <= r_rd[r_rd_ptr];
      r_last_ill  <= w_ctrl > 4'd6;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.opnum1      = w_out_valid ? w_op1 : r_last_op1;
  assign bus.opnum2      = w_out_valid ? w_op2 : r_last_op2;
  assign bus.alu_ctrl    = w_out_valid ? w_ctrl : r_last_ctrl;
  assign bus.out_rd      = w_out_valid ? r_rd[r_rd_ptr] : r_last_rd;
  assign bus.out_illegal = w_out_valid ? w_ctrl > 4'd6 : r_last_ill;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed self-checking bench for alu_operand_stage
module tb_alu_operand_stage;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_operand_stage_if #(.XLEN(32)) bus ();

  alu_operand_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s1, input logic s2, input logic [3:0] ctrl,
                       input logic [3:0] a1, input logic [31:0] d1,
                       input logic [3:0] a2, input logic [31:0] d2,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] rd);
    bus.in_valid    = 1'b1;
    bus.in_src1_sel = s1;
    bus.in_src2_sel = s2;
    bus.in_alu_ctrl = ctrl;
    bus.in_rs1_addr = a1;
    bus.in_rs1_data = d1;
    bus.in_rs2_addr = a2;
    bus.in_rs2_data = d2;
    bus.in_pc       = pc;
    bus.in_imm      = imm;
    bus.in_rd       = rd;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.wb_en = 1'b0;
    bus.wb_rd = 4'd0;
    bus.wb_data = 32'd0;
    drive(2'd0, 1'b0, 4'd0, 4'd0, 32'd0, 4'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    bus.in_valid = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_opnum1", bus.opnum1, 32'd0);
    chk("rst_opnum2", bus.opnum2, 32'd0);
    chk("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    chk("rst_out_illegal", {31'd0, bus.out_illegal}, 32'd0);
    #10 rst = 1'b0;
    tick();

    // single push, pass-through with one-cycle latency
    drive(2'd0, 1'b1, 4'd2, 4'd1, 32'd5, 4'd2, 32'd99, 32'h100, 32'd7, 4'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_opnum1", bus.opnum1, 32'd5);
    chk("t1_opnum2", bus.opnum2, 32'd7);
    chk("t1_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd2);
    tick();
    chk("t1_drained", {31'd0, bus.out_valid}, 32'd0);
    chk("t1_hold_opnum1", bus.opnum1, 32'd5);

    // fill to full, back-pressure, ordered drain, simultaneous push/pop at count 1
    bus.out_ready = 1'b0;
    drive(2'd0, 1'b1, 4'd2, 4'd0, 32'd0, 4'd0, 32'd0, 32'd0, 32'h11, 4'd1);
    tick();
    chk("t2_ready_after_1", {31'd0, bus.in_ready}, 32'd1);
    drive(2'd0, 1'b1, 4'd2, 4'd0, 32'd0, 4'd0, 32'd0, 32'd0, 32'h22, 4'd2);
    tick();
    chk("t2_ready_after_2", {31'd0, bus.in_ready}, 32'd0);
    chk("t2_head_rd", {28'd0, bus.out_rd}, 32'd1);
    drive(2'd0, 1'b1, 4'd2, 4'd0, 32'd0, 4'd0, 32'd0, 32'd0, 32'h33, 4'd3);
    tick();
    chk("t2_still_full", {31'd0, bus.in_ready}, 32'd0);
    chk("t2_head_rd_held", {28'd0, bus.out_rd}, 32'd1);
    chk("t2_head_imm", bus.opnum2, 32'h11);
    bus.out_ready = 1'b1;
    tick();
    chk("t2_ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
    chk("t2_second_rd", {28'd0, bus.out_rd}, 32'd2);
    chk("t2_second_imm", bus.opnum2, 32'h22);
    tick();
    bus.in_valid = 1'b0;
    chk("t2_third_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t2_third_rd", {28'd0, bus.out_rd}, 32'd3);
    chk("t2_third_imm", bus.opnum2, 32'h33);
    tick();
    chk("t2_empty", {31'd0, bus.out_valid}, 32'd0);

    // held-entry snoop, x0 exclusion, capture-time bypass
    bus.out_ready = 1'b0;
    drive(2'd0, 1'b0, 4'd2, 4'd0, 32'd0, 4'd3, 32'h10, 32'd0, 32'd0, 4'd5);
    tick();
    bus.in_valid = 1'b0;
    chk("t3_before_snoop", bus.opnum2, 32'h10);
    bus.wb_en = 1'b1;
    bus.wb_rd = 4'd3;
    bus.wb_data = 32'hABCD;
    tick();
    chk("t3_snooped", bus.opnum2, 32'hABCD);
    bus.wb_rd = 4'd0;
    bus.wb_data = 32'h5555;
    tick();
    bus.wb_en = 1'b0;
    chk("t3_x0_op2", bus.opnum2, 32'hABCD);
    chk("t3_x0_op1", bus.opnum1, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t3_popped", {31'd0, bus.out_valid}, 32'd0);
    drive(2'd0, 1'b1, 4'd2, 4'd4, 32'd1, 4'd0, 32'd0, 32'd0, 32'd0, 4'd6);
    bus.wb_en = 1'b1;
    bus.wb_rd = 4'd4;
    bus.wb_data = 32'h77;
    tick();
    bus.in_valid = 1'b0;
    bus.wb_en = 1'b0;
    chk("t3_bypass", bus.opnum1, 32'h77);
    bus.out_ready = 1'b1;
    tick();

    // shift-amount masking
    drive(2'd0, 1'b0, 4'd3, 4'd0, 32'd1, 4'd2, 32'hFFFF_FFE5, 32'd0, 32'd0, 4'd7);
    tick();
    chk("t4_sll_mask", bus.opnum2, 32'h0000_0005);
    chk("t4_sll_ctrl", {28'd0, bus.alu_ctrl}, 32'd3);
    bus.in_alu_ctrl = 4'd6;
    tick();
    chk("t4_sub_nomask", bus.opnum2, 32'hFFFF_FFE5);
    bus.in_alu_ctrl = 4'd4;
    tick();
    chk("t4_srl_mask", bus.opnum2, 32'h0000_0005);
    bus.in_alu_ctrl = 4'd5;
    tick();
    chk("t4_xor_nomask", bus.opnum2, 32'hFFFF_FFE5);

    // opnum1 source selection and illegal op flag
    drive(2'd1, 1'b1, 4'd2, 4'd1, 32'h1234, 4'd0, 32'd0, 32'h8000_0004, 32'd0, 4'd1);
    tick();
    chk("t5_pc", bus.opnum1, 32'h8000_0004);
    chk("t5_legal", {31'd0, bus.out_illegal}, 32'd0);
    bus.in_alu_ctrl = 4'd9;
    tick();
    chk("t5_illegal", {31'd0, bus.out_illegal}, 32'd1);
    chk("t5_ctrl_passthru", {28'd0, bus.alu_ctrl}, 32'd9);
    bus.in_alu_ctrl = 4'd7;
    bus.in_src1_sel = 2'd2;
    tick();
    chk("t5_ctrl7_illegal", {31'd0, bus.out_illegal}, 32'd1);
    chk("t5_zero_sel", bus.opnum1, 32'd0);
    bus.in_alu_ctrl = 4'd6;
    bus.in_src1_sel = 2'd3;
    tick();
    bus.in_valid = 1'b0;
    chk("t5_ctrl6_legal", {31'd0, bus.out_illegal}, 32'd0);
    chk("t5_rsvd_sel", bus.opnum1, 32'd0);
    tick();
    chk("t5_empty", {31'd0, bus.out_valid}, 32'd0);

    // flush with full FIFO and pending push
    bus.out_ready = 1'b0;
    drive(2'd0, 1'b1, 4'd2, 4'd0, 32'd0, 4'd0, 32'd0, 32'd0, 32'h66, 4'd6);
    tick();
    bus.in_rd = 4'd7;
    tick();
    chk("t6_full", {31'd0, bus.in_ready}, 32'd0);
    bus.in_rd = 4'd8;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("t6_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_flush_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("t6_flush_stays_empty", {31'd0, bus.out_valid}, 32'd0);
    drive(2'd0, 1'b1, 4'd2, 4'd0, 32'd0, 4'd0, 32'd0, 32'd0, 32'h66, 4'd6);
    tick();
    bus.in_rd = 4'd9;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("t6_flush_push_dropped", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("t6_dropped_never_seen", {31'd0, bus.out_valid}, 32'd0);

    // asynchronous reset mid-stream
    drive(2'd0, 1'b1, 4'd5, 4'd1, 32'hDEAD, 4'd0, 32'd0, 32'd0, 32'hBEEF, 4'd4);
    tick();
    tick();
    bus.in_valid = 1'b0;
    chk("t6_pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_arst_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("t6_arst_opnum1", bus.opnum1, 32'd0);
    chk("t6_arst_opnum2", bus.opnum2, 32'd0);
    chk("t6_arst_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    chk("t6_arst_rd", {28'd0, bus.out_rd}, 32'd0);
    #1 rst = 1'b0;
    tick();
    chk("t6_post_rst_empty", {31'd0, bus.out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
